// File: rtl/intra_pkg.sv
// Shared types and constants for the intra edge filter and its 5-tap helper.
package intra_pkg;

  localparam int PXW    = 10;
  localparam int PIXW   = 3 * PXW;
  localparam int MAX_SZ = 17;
  localparam int SZW    = 5;
  localparam int TAPS   = 5;

  // One pixel, V in the top bits and Y in the bottom bits
  typedef struct packed {
    logic [PXW-1:0] v;
    logic [PXW-1:0] u;
    logic [PXW-1:0] y;
  } pixel_t;

  // Smoothing kernels for strengths 1..3; every row sums to 16
  localparam logic [3:0] EDGE_KERNEL [3][5] = '{
    '{4'd0, 4'd4, 4'd8, 4'd4, 4'd0},
    '{4'd0, 4'd5, 4'd6, 4'd5, 4'd0},
    '{4'd2, 4'd4, 4'd4, 4'd4, 4'd2}
  };

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FILTER,
    OUT
  } edge_filt_state_t;

  // Requested edge lengths beyond the buffer depth are clamped to it
  function automatic logic [SZW-1:0] satSize(input logic [SZW-1:0] s);
    return (s > SZW'(MAX_SZ)) ? SZW'(MAX_SZ) : s;
  endfunction

endpackage

// File: rtl/intra_edge_tap5.sv
// Combinational 5-tap smoothing of one colour component with rounding.
module intra_edge_tap5
  import intra_pkg::*;
(
  input  logic [TAPS-1:0][PXW-1:0] samples,
  input  logic [1:0]               strength,
  output logic [PXW-1:0]           result
);

  localparam int SUMW = PXW + 4;

  logic [SUMW-1:0] acc;
  logic [SUMW-1:0] rounded;

  // Weighted sum fits in PXW+4 bits because the kernel sums to 16
  always_comb begin
    acc = '0;
    if (strength == 2'd0) begin
      acc = {samples[2], 4'b0000};
    end else begin
      for (int j = 0; j < TAPS; j++) begin
        acc = acc + SUMW'(EDGE_KERNEL[strength - 2'd1][j]) * SUMW'(samples[j]);
      end
    end
    rounded = acc + SUMW'(8);
    result  = rounded[SUMW-1:4];
  end

endmodule

// File: rtl/intra_edge_filter.sv
// Collects one intra edge from a pixel stream, smooths it per component and
// presents it as a registered parallel array with a valid/ready handshake.
module intra_edge_filter
  import intra_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [SZW-1:0]                sz,
  input  logic [1:0]                    strength,
  output logic                          busy,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [PIXW-1:0]               in_pixel,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SZW-1:0]                out_sz,
  output logic [MAX_SZ-1:0][PIXW-1:0]   out_array
);

  edge_filt_state_t state;

  pixel_t edgeBuf [MAX_SZ];
  pixel_t filtBuf [MAX_SZ];

  logic [SZW-1:0] edgeSz;
  logic [SZW-1:0] cnt;
  logic [SZW-1:0] filtIdx;
  logic [1:0]     edgeStrength;

  logic [TAPS-1:0][PXW-1:0] tapY;
  logic [TAPS-1:0][PXW-1:0] tapU;
  logic [TAPS-1:0][PXW-1:0] tapV;
  logic [PXW-1:0]           resY;
  logic [PXW-1:0]           resU;
  logic [PXW-1:0]           resV;
  pixel_t                   filtPixel;
  pixel_t                   inPix;

  assign inPix     = pixel_t'(in_pixel);
  assign filtPixel = pixel_t'({resV, resU, resY});

  // Gather the five-sample window around filtIdx, replicating the end pixels
  always_comb begin
    int pos;
    pos  = 0;
    tapY = '0;
    tapU = '0;
    tapV = '0;
    for (int j = 0; j < TAPS; j++) begin
      pos = int'(filtIdx) + j - 2;
      if (pos > int'(edgeSz) - 1) pos = int'(edgeSz) - 1;
      if (pos < 0) pos = 0;
      tapY[j] = edgeBuf[SZW'(pos)].y;
      tapU[j] = edgeBuf[SZW'(pos)].u;
      tapV[j] = edgeBuf[SZW'(pos)].v;
    end
  end

  intra_edge_tap5 uTapY (.samples(tapY), .strength(edgeStrength), .result(resY));
  intra_edge_tap5 uTapU (.samples(tapU), .strength(edgeStrength), .result(resU));
  intra_edge_tap5 uTapV (.samples(tapV), .strength(edgeStrength), .result(resV));

  // Control FSM with registered handshake outputs plus the edge and result buffers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      out_sz       <= '0;
      out_array    <= '0;
      edgeSz       <= '0;
      cnt          <= '0;
      filtIdx      <= '0;
      edgeStrength <= '0;
      for (int k = 0; k < MAX_SZ; k++) begin
        edgeBuf[k] <= '0;
        filtBuf[k] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start && (sz != '0)) begin
            state        <= LOAD;
            busy         <= 1'b1;
            in_ready     <= 1'b1;
            cnt          <= '0;
            edgeSz       <= satSize(sz);
            edgeStrength <= strength;
          end
        end

        LOAD: begin
          if (in_valid) begin
            edgeBuf[cnt] <= inPix;
            cnt          <= cnt + 1'b1;
            if (cnt == edgeSz - 1'b1) begin
              in_ready <= 1'b0;
              if ((edgeStrength != 2'd0) && (edgeSz > SZW'(2))) begin
                state   <= FILTER;
                filtIdx <= SZW'(1);
                for (int k = 0; k < MAX_SZ; k++) begin
                  filtBuf[k] <= '0;
                end
                filtBuf[0] <= edgeBuf[0];
              end else begin
                state     <= OUT;
                out_valid <= 1'b1;
                out_sz    <= edgeSz;
                for (int k = 0; k < MAX_SZ; k++) begin
                  if (SZW'(k) < edgeSz) begin
                    out_array[k] <= (SZW'(k) == cnt) ? inPix : edgeBuf[k];
                  end else begin
                    out_array[k] <= '0;
                  end
                end
              end
            end
          end
        end

        FILTER: begin
          filtBuf[filtIdx] <= filtPixel;
          if (filtIdx == edgeSz - 1'b1) begin
            state     <= OUT;
            out_valid <= 1'b1;
            out_sz    <= edgeSz;
            for (int k = 0; k < MAX_SZ; k++) begin
              out_array[k] <= (SZW'(k) == filtIdx) ? filtPixel : filtBuf[k];
            end
          end else begin
            filtIdx <= filtIdx + 1'b1;
          end
        end

        OUT: begin
          if (out_ready) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intra_edge_filter.sv
// Scoreboard bench for intra_edge_filter using hand-computed directed edges.
module tb_intra_edge_filter;
  import intra_pkg::*;

  localparam int ARRW = MAX_SZ * PIXW;

  typedef struct {
    logic [ARRW-1:0] arr;
    logic [SZW-1:0]  sz;
  } expect_t;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic                        start;
  logic [SZW-1:0]              sz;
  logic [1:0]                  strength;
  logic                        busy;
  logic                        in_valid;
  logic                        in_ready;
  logic [PIXW-1:0]             in_pixel;
  logic                        out_valid;
  logic                        out_ready;
  logic [SZW-1:0]              out_sz;
  logic [MAX_SZ-1:0][PIXW-1:0] out_array;

  expect_t                     expQ[$];
  int                          assertCount = 0;
  int                          failCount = 0;
  int                          cycle = 0;
  logic [PIXW-1:0]             stimPix [MAX_SZ];
  logic [MAX_SZ-1:0][PIXW-1:0] expArr;

  intra_edge_filter dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sz(sz), .strength(strength),
    .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .out_sz(out_sz), .out_array(out_array)
  );

  // Free-running clock with a 10-unit period
  always #5 clk = ~clk;

  // Cycle counter used to measure start-to-valid latency
  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [PIXW-1:0] makePix(input int y, input int u, input int v);
    return {PXW'(v), PXW'(u), PXW'(y)};
  endfunction

  task automatic checkOutput(input string name, input logic [ARRW-1:0] act, input logic [ARRW-1:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clearVectors();
    expArr = '0;
    for (int k = 0; k < MAX_SZ; k++) stimPix[k] = '0;
  endtask

  // Monitor: every cycle the array is presented it must match the oldest expected edge
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (expQ.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL unexpected_out_valid: got out_valid=1, expected no pending edge");
      end else begin
        checkOutput("out_array", out_array, expQ[0].arr);
        checkOutput("out_sz", ARRW'(out_sz), ARRW'(expQ[0].sz));
        if (out_ready) void'(expQ.pop_front());
      end
    end
  end

  // Watchdog so a wedged DUT still ends the run
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input int szIn, input logic [1:0] str, input bit stall,
                               input int holdOut, input int expLatency);
    int      beats;
    int      startCycle;
    int      guard;
    bit      accepted;
    expect_t e;
    beats = (szIn > MAX_SZ) ? MAX_SZ : szIn;
    e.arr = expArr;
    e.sz  = SZW'(beats);
    expQ.push_back(e);
    @(posedge clk); #1;
    out_ready  = (holdOut == 0);
    start      = 1'b1;
    sz         = SZW'(szIn);
    strength   = str;
    startCycle = cycle;
    @(posedge clk); #1;
    start = 1'b0;
    for (int b = 0; b < beats; b++) begin
      if (stall) begin
        in_valid = 1'b0;
        start    = 1'b1;
        sz       = SZW'(3);
        @(posedge clk); #1;
        start = 1'b0;
      end
      in_valid = 1'b1;
      in_pixel = stimPix[b];
      accepted = 1'b0;
      guard    = 0;
      while (!accepted && guard < 50) begin
        @(negedge clk);
        accepted = in_ready;
        @(posedge clk); #1;
        guard++;
      end
      if (!accepted) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL load_timeout: beat %0d not accepted, expected in_ready=1", b);
      end
    end
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("out_valid_seen", ARRW'(out_valid), ARRW'(1));
    if (expLatency > 0) checkOutput("latency", ARRW'(cycle - startCycle), ARRW'(expLatency));
    if (holdOut > 0) begin
      for (int h = 0; h < holdOut; h++) begin
        @(posedge clk); #1;
        start = (h == 1);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      start     = 1'b1;
      sz        = SZW'(4);
      strength  = 2'd0;
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput("busy_after_handshake", ARRW'(busy), ARRW'(0));
      checkOutput("valid_after_handshake", ARRW'(out_valid), ARRW'(0));
    end else begin
      guard = 0;
      while (out_valid && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      checkOutput("busy_idle", ARRW'(busy), ARRW'(0));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    sz        = '0;
    strength  = '0;
    in_valid  = 1'b0;
    in_pixel  = '0;
    out_ready = 1'b1;
    #22;
    checkOutput("reset_busy", ARRW'(busy), ARRW'(0));
    checkOutput("reset_in_ready", ARRW'(in_ready), ARRW'(0));
    checkOutput("reset_out_valid", ARRW'(out_valid), ARRW'(0));
    checkOutput("reset_out_sz", ARRW'(out_sz), ARRW'(0));
    checkOutput("reset_out_array", out_array, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("[TB] zero-length start is ignored");
    @(posedge clk); #1;
    start = 1'b1;
    sz    = '0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("sz0_busy", ARRW'(busy), ARRW'(0));
    checkOutput("sz0_in_ready", ARRW'(in_ready), ARRW'(0));

    $display("[TB] strength 1 impulse, sz 4");
    clearVectors();
    stimPix[1] = makePix(160, 0, 0);
    expArr[1]  = makePix(80, 0, 0);
    expArr[2]  = makePix(40, 0, 0);
    applyStimulus(4, 2'd1, 1'b0, 0, 8);

    $display("[TB] strength 3 impulse, sz 4");
    clearVectors();
    stimPix[1] = makePix(160, 0, 0);
    expArr[1]  = makePix(40, 0, 0);
    expArr[2]  = makePix(40, 0, 0);
    expArr[3]  = makePix(20, 0, 0);
    applyStimulus(4, 2'd3, 1'b0, 0, 8);

    $display("[TB] strength 2 full-scale, sz 17");
    clearVectors();
    for (int k = 0; k < 17; k++) begin
      stimPix[k] = makePix(1023, 1023, 1023);
      expArr[k]  = makePix(1023, 1023, 1023);
    end
    applyStimulus(17, 2'd2, 1'b0, 0, 34);

    $display("[TB] strength 0 ramp passthrough, sz 9");
    clearVectors();
    for (int k = 0; k < 9; k++) begin
      stimPix[k] = makePix(k, 3 * k, 0);
      expArr[k]  = makePix(k, 3 * k, 0);
    end
    applyStimulus(9, 2'd0, 1'b0, 0, 10);

    $display("[TB] oversize request saturates to 17");
    clearVectors();
    for (int k = 0; k < 17; k++) begin
      stimPix[k] = makePix(k, 2 * k, 1023 - k);
      expArr[k]  = makePix(k, 2 * k, 1023 - k);
    end
    applyStimulus(20, 2'd0, 1'b0, 0, 18);

    $display("[TB] input stalls and output backpressure, strength 1 sz 5");
    clearVectors();
    stimPix[0] = makePix(16, 0, 1023);
    stimPix[1] = makePix(32, 0, 1023);
    stimPix[2] = makePix(48, 160, 1023);
    stimPix[3] = makePix(64, 0, 1023);
    stimPix[4] = makePix(80, 0, 1023);
    expArr[0]  = makePix(16, 0, 1023);
    expArr[1]  = makePix(32, 40, 1023);
    expArr[2]  = makePix(48, 80, 1023);
    expArr[3]  = makePix(64, 40, 1023);
    expArr[4]  = makePix(76, 0, 1023);
    applyStimulus(5, 2'd1, 1'b1, 5, 0);

    $display("[TB] reset during load");
    @(posedge clk); #1;
    start    = 1'b1;
    sz       = SZW'(8);
    strength = 2'd1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      in_valid = 1'b1;
      in_pixel = makePix(500 + b, 300, 700);
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_busy", ARRW'(busy), ARRW'(0));
    checkOutput("midreset_in_ready", ARRW'(in_ready), ARRW'(0));
    checkOutput("midreset_out_valid", ARRW'(out_valid), ARRW'(0));
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    $display("[TB] fresh edge after reset, strength 3 sz 4");
    clearVectors();
    stimPix[1] = makePix(160, 0, 0);
    expArr[1]  = makePix(40, 0, 0);
    expArr[2]  = makePix(40, 0, 0);
    expArr[3]  = makePix(20, 0, 0);
    applyStimulus(4, 2'd3, 1'b0, 0, 8);

    repeat (4) @(posedge clk);
    checkOutput("scoreboard_empty", ARRW'(expQ.size()), ARRW'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
